// File: rtl/spi_master_if.sv
// Control and serial signal bundle of the SPI master. The master modport is the
// controller's view and the slave modport is the view of the side that drives it.
interface spi_master_if;
    logic       start;
    logic [7:0] data_in;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic       cs;
    logic       busy;
    logic       done;
    logic [7:0] rx;

    modport master (
        input  start,
        input  data_in,
        input  miso,
        output sclk,
        output mosi,
        output cs,
        output busy,
        output done,
        output rx
    );

    modport slave (
        output start,
        output data_in,
        output miso,
        input  sclk,
        input  mosi,
        input  cs,
        input  busy,
        input  done,
        input  rx
    );
endinterface

// File: rtl/spi_master.sv
// SPI master: one full-duplex, 8-bit, MSB-first frame per accepted start request.
// The SPI mode and the SCLK half-period in CLK cycles are set by parameters.
module spi_master #(
    parameter logic [1:0]  MODE    = 2'd3,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    spi_master_if.master bus
);
    localparam logic       CPOL      = MODE[1];
    localparam logic       CPHA      = MODE[0];
    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST = 8'(CLK_DIV);
    localparam logic [4:0] EDGE_LAST = 5'd16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0] r_state;
    logic [7:0] r_div;
    logic [4:0] r_edges;
    logic [7:0] r_tx_sh;
    logic [7:0] r_rx_sh;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_cs;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_rx;

    logic [1:0] w_state_n;
    logic [7:0] w_div_n;
    logic [4:0] w_edges_n;
    logic [7:0] w_tx_sh_n;
    logic [7:0] w_rx_sh_n;
    logic       w_sclk_n;
    logic       w_mosi_n;
    logic       w_cs_n;
    logic       w_busy_n;
    logic       w_done_n;
    logic [7:0] w_rx_n;

    logic       w_div_hit;
    logic       w_hold_hit;
    logic [4:0] w_edge_inc;
    logic       w_sample_edge;

    assign w_div_hit  = (r_div == DIV_LAST);
    assign w_hold_hit = (r_div == HOLD_LAST);
    assign w_edge_inc = r_edges + 5'd1;
    // Odd edges lead; CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
    assign w_sample_edge = w_edge_inc[0] ^ CPHA;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        w_state_n = r_state;
        w_div_n   = r_div;
        w_edges_n = r_edges;
        w_tx_sh_n = r_tx_sh;
        w_rx_sh_n = r_rx_sh;
        w_sclk_n  = r_sclk;
        w_mosi_n  = r_mosi;
        w_cs_n    = r_cs;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        w_rx_n    = r_rx;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_n = ST_SETUP;
                    w_div_n   = 8'd0;
                    w_edges_n = 5'd0;
                    w_rx_sh_n = 8'h00;
                    w_cs_n    = 1'b0;
                    w_busy_n  = 1'b1;
                    if (CPHA) begin
                        w_tx_sh_n = bus.data_in;
                    end else begin
                        w_mosi_n  = bus.data_in[7];
                        w_tx_sh_n = {bus.data_in[6:0], 1'b0};
                    end
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (w_div_hit) begin
                    w_div_n   = 8'd0;
                    w_state_n = ST_XFER;
                end else begin
                    w_div_n = r_div + 8'd1;
                end
            end
            ST_XFER: begin
                if (w_div_hit) begin
                    w_div_n   = 8'd0;
                    w_sclk_n  = ~r_sclk;
                    w_edges_n = w_edge_inc;
                    // No ninth bit is driven on the closing edge of the frame.
                    if (w_sample_edge) begin
                        w_rx_sh_n = {r_rx_sh[6:0], bus.miso};
                    end else if (w_edge_inc != EDGE_LAST) begin
                        w_mosi_n  = r_tx_sh[7];
                        w_tx_sh_n = {r_tx_sh[6:0], 1'b0};
                    end else begin
                        w_mosi_n = r_mosi;
                    end
                    if (w_edge_inc == EDGE_LAST) begin
                        w_state_n = ST_HOLD;
                    end else begin
                        w_state_n = ST_XFER;
                    end
                end else begin
                    w_div_n = r_div + 8'd1;
                end
            end
            ST_HOLD: begin
                if (w_hold_hit) begin
                    w_div_n   = 8'd0;
                    w_cs_n    = 1'b1;
                    w_busy_n  = 1'b0;
                    w_rx_n    = r_rx_sh;
                    w_done_n  = 1'b1;
                    w_state_n = ST_IDLE;
                end else begin
                    w_div_n = r_div + 8'd1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_div_n   = 8'd0;
                w_edges_n = 5'd0;
                w_sclk_n  = CPOL;
                w_cs_n    = 1'b1;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_div   <= 8'd0;
            r_edges <= 5'd0;
            r_tx_sh <= 8'h00;
            r_rx_sh <= 8'h00;
            r_sclk  <= CPOL;
            r_mosi  <= 1'b0;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rx    <= 8'h00;
        end else begin
            r_state <= w_state_n;
            r_div   <= w_div_n;
            r_edges <= w_edges_n;
            r_tx_sh <= w_tx_sh_n;
            r_rx_sh <= w_rx_sh_n;
            r_sclk  <= w_sclk_n;
            r_mosi  <= w_mosi_n;
            r_cs    <= w_cs_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_rx    <= w_rx_n;
        end
    end

    assign bus.sclk = r_sclk;
    assign bus.mosi = r_mosi;
    assign bus.cs   = r_cs;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.rx   = r_rx;
endmodule
